pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter PC_BASE, default 32'h0000_3000, reset PC and low bound of the instruction window.
REQ-002 Parameter SPAN_LOG2, default 16, instruction window size = 2^SPAN_LOG2 bytes; legal range 2..31.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  fetch hold from hazard unit; PC must not advance while high.
REQ-006 is_jal / is_jr / is_branch  input  1 each  redirect-class selects from decode.
REQ-007 branch_taken  input  1  branch comparison result; meaningful only with is_branch.
REQ-008 jal_target / jr_target / branch_target  input  32 each  raw redirect targets.
REQ-009 pc  output  32  current fetch address, registered.
REQ-010 pc_plus4  output  32  wrapped pc+4, combinational from pc.
REQ-011 pending  output  1  high while a redirect captured during stall awaits release.
REQ-012 sel_conflict  output  1  registered one-cycle pulse when more than one select was high.
REQ-013 misalign  output  1  registered one-cycle pulse; present only under PC_ALIGN_CHECK_EN.

Function
REQ-014 Wrap rule: wrap(x) = PC_BASE + ((x - PC_BASE) mod 2^SPAN_LOG2), 32-bit modular subtract, mask low SPAN_LOG2 bits.
REQ-015 Every value loaded into pc or the pending register passes through wrap().
REQ-016 Redirect request = exactly one of: is_jal alone, is_jr alone, is_branch alone with branch_taken=1.
REQ-017 Redirect target = jal_target, jr_target or branch_target respectively.
REQ-018 Two or more selects high in one cycle: no redirect, sequential path used, sel_conflict pulses next cycle.
REQ-019 is_branch alone with branch_taken=0: no redirect, no conflict.
REQ-020 State machine, two states: RUN (reset state), PEND.
REQ-021 RUN, stall=0, redirect: pc <= wrap(target) next edge; stay RUN.
REQ-022 RUN, stall=0, no redirect: pc <= wrap(pc+4); stay RUN.
REQ-023 RUN, stall=1, redirect: pc holds; pend_target <= wrap(target); go PEND.
REQ-024 RUN, stall=1, no redirect: pc holds; stay RUN.
REQ-025 PEND, stall=1: pc holds; a new redirect overwrites pend_target (latest wins); stay PEND.
REQ-026 PEND, stall=0, no redirect: pc <= pend_target; go RUN.
REQ-027 PEND, stall=0, redirect same cycle: pc <= wrap(new target); pend_target discarded; go RUN.
REQ-028 pending = (state == PEND); latency from capturing edge to pending high is zero cycles after that edge.
REQ-029 Redirect latency: pc shows target on the first edge where stall=0 with the redirect or pending in effect.
REQ-030 pc_plus4 at top of window wraps to PC_BASE (default: pc=0x0001_2FFC -> pc_plus4=0x0000_3000).

Reset
REQ-031 reset=1 at a clock edge: pc <= PC_BASE, state <= RUN, pend_target <= PC_BASE, sel_conflict <= 0, misalign <= 0.
REQ-032 reset dominates stall and all selects, including while in PEND; the pending redirect is lost.
REQ-033 First fetch after reset release is PC_BASE, then PC_BASE+4 if no stall or redirect.

Configuration
REQ-034 Macro PC_ALIGN_CHECK_EN defined: a redirect target with bits[1:0] != 0 is still accepted with bits[1:0] forced to 0. misalign pulses one cycle after the acceptance edge (immediate load or pending capture).
REQ-035 Macro PC_ALIGN_CHECK_EN undefined: bits[1:0] of targets are forced to 0 silently; the misalign port is absent.

Verification
REQ-036 Reset, then 3 edges with no stall or selects -> pc = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-037 is_jal=1, jal_target=0x0001_3004, stall=0 -> next pc = 0x0000_3004 (wrapped); is_jr with jr_target=0x2FFC -> pc = 0x0001_2FFC.
REQ-038 stall=1 with is_branch=1, branch_taken=1, target 0x3100 -> pending=1, pc held. Stall for 2 more cycles, then stall=0 -> pc = 0x3100, pending=0.
REQ-039 PEND with target 0x3100; stall=0 and is_jr=1, jr_target 0x3200 -> pc = 0x3200. Separately, is_jal=1 and is_jr=1 together -> pc+4, sel_conflict=1 for one cycle.
REQ-040 In PEND, assert reset -> pc = 0x3000, pending=0. Under PC_ALIGN_CHECK_EN, jal_target 0x3006 -> pc = 0x3004, misalign=1 for one cycle.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential, redirect and stall-deferred redirect
// paths, all confined to a 2^SPAN_LOG2-byte window. Optional macro: PC_ALIGN_CHECK_EN.
module pc_gen #(
  parameter logic [31:0] PC_BASE   = 32'h0000_3000,
  parameter int unsigned SPAN_LOG2 = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_jal,
  input  logic        is_jr,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [31:0] jal_target,
  input  logic [31:0] jr_target,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pending,
`ifdef PC_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        sel_conflict
);

  localparam logic [31:0] SPAN_MASK  = (32'd1 << SPAN_LOG2) - 32'd1;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_target;
  logic        r_sel_conflict;

  logic [1:0]  w_sel_cnt;
  logic        w_conflict;
  logic        w_redirect;
  logic [31:0] w_raw_target;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  // Fold any address back into the instruction window.
  function automatic logic [31:0] wrap(input logic [31:0] x);
    return PC_BASE + ((x - PC_BASE) & SPAN_MASK);
  endfunction

  // Select decode: a redirect needs exactly one select, and a taken branch.
  always_comb begin
    w_sel_cnt    = 2'(is_jal) + 2'(is_jr) + 2'(is_branch);
    w_conflict   = (w_sel_cnt > 2'd1);
    w_redirect   = !w_conflict && (is_jal || is_jr || (is_branch && branch_taken));
    w_raw_target = branch_target;
    if (is_jal) begin
      w_raw_target = jal_target;
    end else if (is_jr) begin
      w_raw_target = jr_target;
    end
    w_target   = wrap(w_raw_target & ALIGN_MASK);
    w_pc_plus4 = wrap(r_pc + 32'd4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= RUN;
      r_pc           <= PC_BASE;
      r_pend_target  <= PC_BASE;
      r_sel_conflict <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign       <= 1'b0;
`endif
    end else begin
      r_sel_conflict <= w_conflict;
`ifdef PC_ALIGN_CHECK_EN
      // Every redirect is accepted in every state, so flag on acceptance directly.
      misalign       <= w_redirect && (w_raw_target[1:0] != 2'b00);
`endif
      case (r_state)
        RUN: begin
          if (!stall) begin
            r_pc <= w_redirect ? w_target : w_pc_plus4;
          end else if (w_redirect) begin
            r_pend_target <= w_target;
            r_state       <= PEND;
          end
        end
        PEND: begin
          if (stall) begin
            if (w_redirect) begin
              r_pend_target <= w_target;
            end
          end else begin
            // A fresh redirect on the release cycle supersedes the deferred one.
            r_pc    <= w_redirect ? w_target : r_pend_target;
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign pending      = (r_state == PEND);
  assign sel_conflict = r_sel_conflict;

endmodule
